// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: a circular buffer of {instr, pc} entries
// with a registered occupancy count, flush-to-empty and a sticky overflow flag.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_in,
    input  logic                       push_valid_in,
    input  logic [XLEN-1:0]            push_instr_in,
    input  logic [XLEN-1:0]            push_pc_in,
    output logic                       push_ready_out,
    output logic                       pop_valid_out,
    output logic [XLEN-1:0]            pop_instr_out,
    output logic [XLEN-1:0]            pop_pc_out,
    input  logic                       pop_ready_in,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       overflow_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            do_push;
    logic            do_pop;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. Ready and valid come only from the registered count, so neither
    // side has a combinational path to the other.
    assign push_ready_out = (count != FULL);
    assign pop_valid_out  = (count != '0);
    assign do_push        = push_valid_in && push_ready_out;
    assign do_pop         = pop_valid_out && pop_ready_in;

    // No bypass: an empty queue always presents a NOP, never the incoming push.
    assign pop_instr_out  = pop_valid_out ? instr_mem[rptr] : NOP_INSTR;
    assign pop_pc_out     = pop_valid_out ? pc_mem[rptr] : '0;
    assign count_out      = count;
    assign overflow_out   = overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_valid_in && !push_ready_out) begin
                overflow <= 1'b1;
            end
            if (flush_in) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (do_push) begin
                    wptr <= wptr + 1'b1;
                end
                if (do_pop) begin
                    rptr <= rptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage is not reset; count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush_in) begin
            instr_mem[wptr] <= push_instr_in;
            pc_mem[wptr]    <= push_pc_in;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, single transfer, full/overflow,
// streaming with wrap-around, flush priority and asynchronous reset.
module tb_fetch_queue;
    logic        clk;
    logic        rst_n;
    logic        flush_in;
    logic        push_valid_in;
    logic [31:0] push_instr_in;
    logic [31:0] push_pc_in;
    logic        push_ready_out;
    logic        pop_valid_out;
    logic [31:0] pop_instr_out;
    logic [31:0] pop_pc_out;
    logic        pop_ready_in;
    logic [2:0]  count_out;
    logic        overflow_out;

    int n_cmp;
    int n_fail;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_queue #(.DEPTH(4), .XLEN(32), .NOP_INSTR(32'h00000013)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_in       (flush_in),
        .push_valid_in  (push_valid_in),
        .push_instr_in  (push_instr_in),
        .push_pc_in     (push_pc_in),
        .push_ready_out (push_ready_out),
        .pop_valid_out  (pop_valid_out),
        .pop_instr_out  (pop_instr_out),
        .pop_pc_out     (pop_pc_out),
        .pop_ready_in   (pop_ready_in),
        .count_out      (count_out),
        .overflow_out   (overflow_out)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0093};
    endfunction

    // Advance past the next rising edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [31:0] pc);
        push_valid_in = v;
        push_pc_in    = pc;
        push_instr_in = instr_of(pc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (pop_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid_out); end
        n_cmp++; if (pop_instr_out !== NOP) begin n_fail++; $display("FAIL reset_pop_instr: got %h expected %h", pop_instr_out, NOP); end
        n_cmp++; if (pop_pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pop_pc: got %h expected 0", pop_pc_out); end
        n_cmp++; if (push_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %b expected 1", push_ready_out); end
        n_cmp++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow_out); end
    endtask

    task automatic test_single();
        push_valid_in = 1'b1;
        push_instr_in = 32'h00500093;
        push_pc_in    = 32'h0;
        n_cmp++; if (pop_valid_out !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0", pop_valid_out); end
        step();
        push_valid_in = 1'b0;
        n_cmp++; if (pop_valid_out !== 1'b1) begin n_fail++; $display("FAIL single_pop_valid: got %b expected 1", pop_valid_out); end
        n_cmp++; if (pop_instr_out !== 32'h00500093) begin n_fail++; $display("FAIL single_pop_instr: got %h expected 00500093", pop_instr_out); end
        n_cmp++; if (pop_pc_out !== 32'h0) begin n_fail++; $display("FAIL single_pop_pc: got %h expected 0", pop_pc_out); end
        n_cmp++; if (count_out !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", count_out); end
        pop_ready_in = 1'b1;
        step();
        pop_ready_in = 1'b0;
        n_cmp++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", count_out); end
        n_cmp++; if (pop_valid_out !== 1'b0) begin n_fail++; $display("FAIL single_empty_valid: got %b expected 0", pop_valid_out); end
        n_cmp++; if (pop_instr_out !== NOP) begin n_fail++; $display("FAIL single_empty_instr: got %h expected %h", pop_instr_out, NOP); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_q[$];
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 32'(i * 4));
            exp_q.push_back(32'(i * 4));
            step();
        end
        set_push(1'b0, 32'h0);
        n_cmp++; if (count_out !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count_out); end
        n_cmp++; if (push_ready_out !== 1'b0) begin n_fail++; $display("FAIL fill_push_ready: got %b expected 0", push_ready_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL fill_no_overflow_yet: got %b expected 0", overflow_out); end
        // Fifth push with decode stalled: dropped, overflow sets, head held.
        set_push(1'b1, 32'd16);
        step();
        set_push(1'b0, 32'h0);
        n_cmp++; if (count_out !== 3'd4) begin n_fail++; $display("FAIL fill_drop_count: got %0d expected 4", count_out); end
        n_cmp++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b expected 1", overflow_out); end
        n_cmp++; if (pop_pc_out !== 32'h0) begin n_fail++; $display("FAIL fill_head_stable: got %h expected 0", pop_pc_out); end
        // Push against a full queue while popping: pop happens, push still dropped.
        set_push(1'b1, 32'd20);
        pop_ready_in = 1'b1;
        step();
        set_push(1'b0, 32'h0);
        void'(exp_q.pop_front());
        n_cmp++; if (count_out !== 3'd3) begin n_fail++; $display("FAIL full_push_pop_count: got %0d expected 3", count_out); end
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_cmp++; if (pop_pc_out !== e || pop_instr_out !== instr_of(e)) begin n_fail++; $display("FAIL fill_drain: got pc %h instr %h expected pc %h instr %h", pop_pc_out, pop_instr_out, e, instr_of(e)); end
            step();
        end
        pop_ready_in = 1'b0;
        n_cmp++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL fill_drained_count: got %0d expected 0", count_out); end
        n_cmp++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_sticky: got %b expected 1", overflow_out); end
    endtask

    task automatic test_back_to_back();
        set_push(1'b1, 32'd0);
        step();
        set_push(1'b1, 32'd4);
        step();
        pop_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_push(1'b1, 32'(8 + 4 * i));
            n_cmp++; if (pop_pc_out !== 32'(4 * i)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, pop_pc_out, 32'(4 * i)); end
            step();
            n_cmp++; if (count_out !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count_out); end
        end
        set_push(1'b0, 32'h0);
        n_cmp++; if (pop_pc_out !== 32'd40) begin n_fail++; $display("FAIL b2b_tail0: got %h expected 28", pop_pc_out); end
        step();
        n_cmp++; if (pop_pc_out !== 32'd44) begin n_fail++; $display("FAIL b2b_tail1: got %h expected 2c", pop_pc_out); end
        step();
        pop_ready_in = 1'b0;
        n_cmp++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d expected 0", count_out); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h100 + 32'(4 * i));
            step();
        end
        flush_in     = 1'b1;
        pop_ready_in = 1'b1;
        set_push(1'b1, 32'h200);
        step();
        flush_in     = 1'b0;
        pop_ready_in = 1'b0;
        set_push(1'b0, 32'h0);
        n_cmp++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count_out); end
        n_cmp++; if (pop_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_pop_valid: got %b expected 0", pop_valid_out); end
        n_cmp++; if (pop_instr_out !== NOP) begin n_fail++; $display("FAIL flush_pop_instr: got %h expected %h", pop_instr_out, NOP); end
        n_cmp++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_overflow: got %b expected 1", overflow_out); end
        set_push(1'b1, 32'h80);
        step();
        set_push(1'b0, 32'h0);
        n_cmp++; if (pop_pc_out !== 32'h80 || count_out !== 3'd1) begin n_fail++; $display("FAIL flush_first_after: got pc %h count %0d expected pc 80 count 1", pop_pc_out, count_out); end
        pop_ready_in = 1'b1;
        step();
        pop_ready_in = 1'b0;
        n_cmp++; if (pop_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_after_drain: got %b expected 0", pop_valid_out); end
    endtask

    task automatic test_async_reset();
        set_push(1'b1, 32'h300);
        step();
        set_push(1'b1, 32'h304);
        step();
        set_push(1'b0, 32'h0);
        n_cmp++; if (count_out !== 3'd2) begin n_fail++; $display("FAIL arst_pre_count: got %0d expected 2", count_out); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pop_valid_out !== 1'b0) begin n_fail++; $display("FAIL arst_pop_valid: got %b expected 0", pop_valid_out); end
        n_cmp++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL arst_overflow: got %b expected 0", overflow_out); end
        n_cmp++; if (pop_instr_out !== NOP) begin n_fail++; $display("FAIL arst_pop_instr: got %h expected %h", pop_instr_out, NOP); end
        step();
        rst_n = 1'b1;
        set_push(1'b1, 32'h400);
        step();
        set_push(1'b0, 32'h0);
        n_cmp++; if (pop_pc_out !== 32'h400 || count_out !== 3'd1) begin n_fail++; $display("FAIL arst_post_push: got pc %h count %0d expected pc 400 count 1", pop_pc_out, count_out); end
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        flush_in      = 1'b0;
        push_valid_in = 1'b0;
        push_instr_in = 32'h0;
        push_pc_in    = 32'h0;
        pop_ready_in  = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
